// File: rtl/axi_color_palette.sv
// Double-buffered colour palette behind an AXI4-Lite slave; software fills the shadow bank,
// a frame-start pulse after a commit request copies it to the active bank that feeds pixel lookup.
module axi_color_palette #(
  parameter int NUM_COLORS  = 16,
  parameter int COLOR_WIDTH = 24,
  parameter int ADDR_WIDTH  = 8,
  parameter int INDEX_WIDTH = 6
) (
  input  logic                   ACLK,
  input  logic                   ARESETN,
  input  logic [ADDR_WIDTH-1:0]  AWADDR,
  input  logic                   AWVALID,
  output logic                   AWREADY,
  input  logic [31:0]            WDATA,
  input  logic [3:0]             WSTRB,
  input  logic                   WVALID,
  output logic                   WREADY,
  output logic [1:0]             BRESP,
  output logic                   BVALID,
  input  logic                   BREADY,
  input  logic [ADDR_WIDTH-1:0]  ARADDR,
  input  logic                   ARVALID,
  output logic                   ARREADY,
  output logic [31:0]            RDATA,
  output logic [1:0]             RRESP,
  output logic                   RVALID,
  input  logic                   RREADY,
  input  logic                   frame_start,
  input  logic [INDEX_WIDTH-1:0] pix_index,
  output logic [COLOR_WIDTH-1:0] pix_color
);

  typedef logic [ADDR_WIDTH-3:0] word_t;
  localparam word_t      CTRL_WORD   = word_t'(0);
  localparam word_t      STATUS_WORD = word_t'(1);
  localparam int         ENTRY_BASE  = 16;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [COLOR_WIDTH-1:0] shadow_q [NUM_COLORS];
  logic [COLOR_WIDTH-1:0] shadow_d [NUM_COLORS];
  logic [COLOR_WIDTH-1:0] active_q [NUM_COLORS];
  logic [COLOR_WIDTH-1:0] active_d [NUM_COLORS];
  logic                   imm_q, imm_d, pending_q, pending_d;
  logic [7:0]             commit_cnt_q, commit_cnt_d;
  logic                   awready_q, awready_d, bvalid_q, bvalid_d;
  logic [1:0]             bresp_q, bresp_d, rresp_q, rresp_d;
  logic                   arready_q, arready_d, rvalid_q, rvalid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [COLOR_WIDTH-1:0] pix_color_q, pix_color_d;
  logic                   wr_fire, rd_fire, commit;
  word_t                  wr_word, rd_word;
  logic                   unused_addr_lsb;

  assign unused_addr_lsb = ^{AWADDR[1:0], ARADDR[1:0]};
  assign wr_word = AWADDR[ADDR_WIDTH-1:2];
  assign rd_word = ARADDR[ADDR_WIDTH-1:2];

  // Byte-strobe merge on the zero-extended entry; bits above COLOR_WIDTH fall off.
  function automatic logic [COLOR_WIDTH-1:0] merge_bytes(input logic [COLOR_WIDTH-1:0] old,
                                                         input logic [31:0] wdata,
                                                         input logic [3:0]  strb);
    logic [31:0] w;
    w = 32'(old);
    for (int k = 0; k < 4; k++)
      if (strb[k]) w[8*k +: 8] = wdata[8*k +: 8];
    return w[COLOR_WIDTH-1:0];
  endfunction

  always_comb begin
    wr_fire      = awready_q && AWVALID && WVALID;
    rd_fire      = arready_q && ARVALID;
    commit       = frame_start && pending_q;
    shadow_d     = shadow_q;
    active_d     = active_q;
    imm_d        = imm_q;
    pending_d    = pending_q;
    commit_cnt_d = commit_cnt_q;
    awready_d    = AWVALID && WVALID && !bvalid_q && !awready_q;
    bvalid_d     = bvalid_q && !BREADY;
    bresp_d      = bresp_q;
    arready_d    = ARVALID && !rvalid_q && !arready_q;
    rvalid_d     = rvalid_q && !RREADY;
    rdata_d      = rdata_q;
    rresp_d      = rresp_q;
    pix_color_d  = '0;

    // Commit is resolved first so a same-cycle COMMIT write re-arms pending and
    // a same-cycle entry write leaves the active bank with the pre-write shadow.
    if (commit) begin
      active_d     = shadow_q;
      pending_d    = 1'b0;
      commit_cnt_d = commit_cnt_q + 8'd1;
    end

    if (wr_fire) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_SLVERR;
      if (wr_word == CTRL_WORD) begin
        bresp_d = RESP_OKAY;
        if (WSTRB[0]) begin
          imm_d = WDATA[1];
          if (WDATA[0]) pending_d = 1'b1;
        end
      end
      for (int i = 0; i < NUM_COLORS; i++) begin
        if (wr_word == word_t'(ENTRY_BASE + i)) begin
          bresp_d     = RESP_OKAY;
          shadow_d[i] = merge_bytes(shadow_q[i], WDATA, WSTRB);
          if (imm_q) active_d[i] = shadow_d[i];
        end
      end
    end

    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      rresp_d  = RESP_SLVERR;
      if (rd_word == CTRL_WORD) begin
        rdata_d = {30'b0, imm_q, 1'b0};
        rresp_d = RESP_OKAY;
      end
      if (rd_word == STATUS_WORD) begin
        rdata_d = {16'b0, commit_cnt_q, 7'b0, pending_q};
        rresp_d = RESP_OKAY;
      end
      for (int i = 0; i < NUM_COLORS; i++) begin
        if (rd_word == word_t'(ENTRY_BASE + i)) begin
          rdata_d = 32'(shadow_q[i]);
          rresp_d = RESP_OKAY;
        end
      end
    end

    // Out-of-range indices match no entry and yield black.
    for (int i = 0; i < NUM_COLORS; i++)
      if (pix_index == INDEX_WIDTH'(i)) pix_color_d = active_q[i];
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      shadow_q     <= '{default: '0};
      active_q     <= '{default: '0};
      imm_q        <= 1'b0;
      pending_q    <= 1'b0;
      commit_cnt_q <= 8'd0;
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      bresp_q      <= 2'b00;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= 32'd0;
      rresp_q      <= 2'b00;
      pix_color_q  <= '0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      imm_q        <= imm_d;
      pending_q    <= pending_d;
      commit_cnt_q <= commit_cnt_d;
      awready_q    <= awready_d;
      bvalid_q     <= bvalid_d;
      bresp_q      <= bresp_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
      rdata_q      <= rdata_d;
      rresp_q      <= rresp_d;
      pix_color_q  <= pix_color_d;
    end
  end

  assign AWREADY   = awready_q;
  assign WREADY    = awready_q;
  assign BVALID    = bvalid_q;
  assign BRESP     = bresp_q;
  assign ARREADY   = arready_q;
  assign RVALID    = rvalid_q;
  assign RDATA     = rdata_q;
  assign RRESP     = rresp_q;
  assign pix_color = pix_color_q;

endmodule

// File: tb/tb_axi_color_palette.sv
// Directed bench for axi_color_palette: register access, double-buffered commit,
// IMMEDIATE mode, B-channel back-pressure and asynchronous reset.
module tb_axi_color_palette;

  localparam int LIMIT = 20;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [7:0]  AWADDR, ARADDR;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic [31:0] WDATA, RDATA;
  logic [3:0]  WSTRB;
  logic [1:0]  BRESP, RRESP;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic        frame_start;
  logic [5:0]  pix_index;
  logic [23:0] pix_color;

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  axi_color_palette #(.NUM_COLORS(16), .COLOR_WIDTH(24), .ADDR_WIDTH(8), .INDEX_WIDTH(6)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .frame_start(frame_start), .pix_index(pix_index), .pix_color(pix_color)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input bit fs, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    AWADDR = addr; WDATA = data; WSTRB = strb; AWVALID = 1'b1; WVALID = 1'b1;
    n = 0;
    while (AWREADY !== 1'b1 && n < LIMIT) begin @(negedge ACLK); n++; end
    chk("aw_timeout", 32'(n >= LIMIT), 32'd0);
    if (fs) frame_start = 1'b1;
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0; frame_start = 1'b0;
    n = 0;
    while (BVALID !== 1'b1 && n < LIMIT) begin @(negedge ACLK); n++; end
    chk("b_timeout", 32'(n >= LIMIT), 32'd0);
    resp = BRESP;
    @(posedge ACLK); #1;
  endtask

  task automatic axi_read(input logic [7:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge ACLK);
    ARADDR = addr; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < LIMIT) begin @(negedge ACLK); n++; end
    chk("ar_timeout", 32'(n >= LIMIT), 32'd0);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    n = 0;
    while (RVALID !== 1'b1 && n < LIMIT) begin @(negedge ACLK); n++; end
    chk("r_timeout", 32'(n >= LIMIT), 32'd0);
    data = RDATA; resp = RRESP;
    if (RREADY) begin @(posedge ACLK); #1; end
  endtask

  task automatic pulse_frame();
    @(negedge ACLK); frame_start = 1'b1;
    @(negedge ACLK); frame_start = 1'b0;
  endtask

  task automatic pix_chk(input string tag, input logic [5:0] idx, input logic [23:0] exp);
    @(negedge ACLK); pix_index = idx;
    @(negedge ACLK);
    chk(tag, 32'(pix_color), 32'(exp));
  endtask

  task automatic reg_chk(input string tag, input logic [7:0] addr, input logic [31:0] exp,
                         input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(addr, d, r);
    chk(tag, d, exp);
    chk({tag, "_rresp"}, 32'(r), 32'(exp_resp));
  endtask

  initial begin
    logic [1:0] resp;
    int n;
    ARESETN = 1'b0; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b1; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b1; frame_start = 1'b0; pix_index = '0;
    repeat (3) @(negedge ACLK);
    chk("rst_awready", 32'(AWREADY), 0);
    chk("rst_wready",  32'(WREADY), 0);
    chk("rst_bvalid",  32'(BVALID), 0);
    chk("rst_arready", 32'(ARREADY), 0);
    chk("rst_rvalid",  32'(RVALID), 0);
    chk("rst_rdata",   RDATA, 0);
    chk("rst_pix",     32'(pix_color), 0);
    ARESETN = 1'b1;

    // Basic entry write/read; active bank untouched before commit.
    axi_write(8'h40, 32'h00FF8040, 4'hF, 0, resp);
    chk("wr40_bresp", 32'(resp), 0);
    reg_chk("rd40", 8'h40, 32'h00FF8040, 2'b00);
    pix_chk("pix0_precommit", 6'd0, 24'h0);

    axi_write(8'h00, 32'h1, 4'hF, 0, resp);
    chk("ctrl_bresp", 32'(resp), 0);
    reg_chk("status_pending", 8'h04, 32'h00000001, 2'b00);
    pulse_frame();
    reg_chk("status_commit1", 8'h04, 32'h00000100, 2'b00);
    pix_chk("pix0_commit", 6'd0, 24'hFF8040);

    // Strobes, width truncation, error responses.
    axi_write(8'h44, 32'hAABBCCDD, 4'b0010, 0, resp);
    reg_chk("rd44_strb", 8'h44, 32'h0000CC00, 2'b00);
    axi_write(8'h04, 32'hFFFFFFFF, 4'hF, 0, resp);
    chk("wr_status_slverr", 32'(resp), 32'h2);
    axi_write(8'h80, 32'h12345678, 4'hF, 0, resp);
    chk("wr_unmapped_slverr", 32'(resp), 32'h2);
    reg_chk("rd80_unmapped", 8'h80, 32'h0, 2'b10);
    reg_chk("status_after_slverr", 8'h04, 32'h00000100, 2'b00);

    // COMMIT write coincident with frame_start commits only on the next frame.
    axi_write(8'h00, 32'h1, 4'hF, 1, resp);
    reg_chk("status_same_cycle", 8'h04, 32'h00000101, 2'b00);
    pix_chk("pix1_not_committed", 6'd1, 24'h0);
    pulse_frame();
    reg_chk("status_commit2", 8'h04, 32'h00000200, 2'b00);
    pix_chk("pix1_committed", 6'd1, 24'h00CC00);

    // Entry write coincident with a commit: active takes the old shadow value.
    axi_write(8'h00, 32'h1, 4'hF, 0, resp);
    axi_write(8'h48, 32'h00111111, 4'hF, 1, resp);
    reg_chk("status_commit3", 8'h04, 32'h00000300, 2'b00);
    pix_chk("pix2_prewrite", 6'd2, 24'h0);
    reg_chk("rd48_shadow", 8'h48, 32'h00111111, 2'b00);

    // IMMEDIATE mode and out-of-range lookup.
    axi_write(8'h00, 32'h2, 4'hF, 0, resp);
    reg_chk("ctrl_imm", 8'h00, 32'h2, 2'b00);
    axi_write(8'h48, 32'h00123456, 4'hF, 0, resp);
    pix_chk("pix2_immediate", 6'd2, 24'h123456);
    pix_chk("pix16_range", 6'd16, 24'h0);
    pix_chk("pix63_range", 6'd63, 24'h0);
    pulse_frame();
    reg_chk("status_no_pending", 8'h04, 32'h00000300, 2'b00);

    // Commit counter wrap.
    for (int i = 0; i < 252; i++) begin
      axi_write(8'h00, 32'h3, 4'hF, 0, resp);
      pulse_frame();
    end
    reg_chk("status_cnt255", 8'h04, 32'h0000FF00, 2'b00);
    axi_write(8'h00, 32'h3, 4'hF, 0, resp);
    pulse_frame();
    reg_chk("status_cnt_wrap", 8'h04, 32'h00000000, 2'b00);

    // B back-pressure blocks a second write until the response drains.
    BREADY = 1'b0;
    axi_write(8'h4C, 32'h0000ABCD, 4'hF, 0, resp);
    chk("stall_first_bresp", 32'(resp), 0);
    @(negedge ACLK);
    AWADDR = 8'h50; WDATA = 32'h00654321; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      chk("stall_awready", 32'(AWREADY), 0);
    end
    chk("stall_bvalid_held", 32'(BVALID), 1);
    BREADY = 1'b1;
    @(negedge ACLK);
    chk("post_b_awready0", 32'(AWREADY), 0);
    @(negedge ACLK);
    chk("post_b_awready1", 32'(AWREADY), 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    n = 0;
    while (BVALID !== 1'b1 && n < LIMIT) begin @(negedge ACLK); n++; end
    chk("second_b_timeout", 32'(n >= LIMIT), 0);
    chk("second_bresp", 32'(BRESP), 0);
    @(posedge ACLK); #1;
    reg_chk("rd50", 8'h50, 32'h00654321, 2'b00);

    // Asynchronous reset in the middle of a read response.
    RREADY = 1'b0;
    @(negedge ACLK);
    ARADDR = 8'h40; ARVALID = 1'b1;
    n = 0;
    while (ARREADY !== 1'b1 && n < LIMIT) begin @(negedge ACLK); n++; end
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    n = 0;
    while (RVALID !== 1'b1 && n < LIMIT) begin @(negedge ACLK); n++; end
    chk("midread_rvalid", 32'(RVALID), 1);
    #2 ARESETN = 1'b0;
    #1;
    chk("async_rst_rvalid", 32'(RVALID), 0);
    chk("async_rst_pix", 32'(pix_color), 0);
    RREADY = 1'b1;
    @(negedge ACLK); @(negedge ACLK);
    ARESETN = 1'b1;
    reg_chk("rst_shadow_cleared", 8'h40, 32'h0, 2'b00);
    pix_chk("rst_active_cleared", 6'd0, 24'h0);
    reg_chk("rst_status_cleared", 8'h04, 32'h0, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
